// File: rtl/crypt_sched.sv
// Two-requester round-robin scheduler for one shared cipher engine.
// One job runs at a time. A job that the engine does not answer within TIMEOUT cycles returns an error result.
module crypt_sched #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         r0_vld,
   output logic         r0_rdy,
   input  logic [63:0]  r0_din,
   input  logic [127:0] r0_key,
   input  logic         r0_mode,
   input  logic         r1_vld,
   output logic         r1_rdy,
   input  logic [63:0]  r1_din,
   input  logic [127:0] r1_key,
   input  logic         r1_mode,
   output logic [63:0]  eng_din,
   output logic [127:0] eng_key,
   output logic         eng_mode,
   output logic         eng_di_vld,
   input  logic [63:0]  eng_dout,
   input  logic         eng_do_vld,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic         out_id,
   output logic [63:0]  out_data,
   output logic         out_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   state_t     state, state_nx;
   logic       rr;
   logic       owner;
   logic [7:0] cnt;
   logic       gnt0, gnt1;
   logic       tmo_hit;

   // A grant in the same cycle as clr would be lost, so no strobe is shown then.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (state == IDLE && !clr) begin
         if (r0_vld && (!r1_vld || !rr)) gnt0 = 1'b1;
         else if (r1_vld)                gnt1 = 1'b1;
      end
   end

   assign r0_rdy     = gnt0;
   assign r1_rdy     = gnt1;
   assign eng_di_vld = (state == ISSUE);
   assign out_vld    = (state == RESP);
   assign tmo_hit    = (cnt + 8'd1 == TMO);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:  if (gnt0 || gnt1) state_nx = ISSUE;
         ISSUE: state_nx = WAIT;
         WAIT:  if (eng_do_vld || tmo_hit) state_nx = RESP;
         RESP:  if (out_rdy) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= IDLE;
         rr       <= 1'b0;
         owner    <= 1'b0;
         cnt      <= 8'd0;
         eng_din  <= 64'd0;
         eng_key  <= 128'd0;
         eng_mode <= 1'b0;
         out_id   <= 1'b0;
         out_data <= 64'd0;
         out_err  <= 1'b0;
      end else begin
         state <= state_nx;
         if (gnt0) begin
            eng_din  <= r0_din;
            eng_key  <= r0_key;
            eng_mode <= r0_mode;
            owner    <= 1'b0;
            rr       <= 1'b1;
         end else if (gnt1) begin
            eng_din  <= r1_din;
            eng_key  <= r1_key;
            eng_mode <= r1_mode;
            owner    <= 1'b1;
            rr       <= 1'b0;
         end
         if (state == ISSUE) cnt <= 8'd0;
         // Result fields change only on entry to RESP, so they stay stable through backpressure.
         if (state == WAIT) begin
            cnt <= cnt + 8'd1;
            if (eng_do_vld) begin
               out_data <= eng_dout;
               out_err  <= 1'b0;
               out_id   <= owner;
            end else if (tmo_hit) begin
               out_data <= 64'd0;
               out_err  <= 1'b1;
               out_id   <= owner;
            end
         end
      end
   end

endmodule

// File: tb/tb_crypt_sched.sv
// Directed bench for crypt_sched: cycle vectors from a table, then hand sequences for
// timeout, backpressure, the timeout/response race and reset in the middle of a job.
module tb_crypt_sched;

   logic         clk = 1'b0;
   logic         clr;
   logic         r0_vld, r0_rdy, r0_mode;
   logic [63:0]  r0_din;
   logic [127:0] r0_key;
   logic         r1_vld, r1_rdy, r1_mode;
   logic [63:0]  r1_din;
   logic [127:0] r1_key;
   logic [63:0]  eng_din, eng_dout;
   logic [127:0] eng_key;
   logic         eng_mode, eng_di_vld, eng_do_vld;
   logic         out_vld, out_rdy, out_id, out_err;
   logic [63:0]  out_data;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   crypt_sched #(.TIMEOUT(64)) dut (
      .clk(clk), .clr(clr),
      .r0_vld(r0_vld), .r0_rdy(r0_rdy), .r0_din(r0_din), .r0_key(r0_key), .r0_mode(r0_mode),
      .r1_vld(r1_vld), .r1_rdy(r1_rdy), .r1_din(r1_din), .r1_key(r1_key), .r1_mode(r1_mode),
      .eng_din(eng_din), .eng_key(eng_key), .eng_mode(eng_mode), .eng_di_vld(eng_di_vld),
      .eng_dout(eng_dout), .eng_do_vld(eng_do_vld),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_id(out_id), .out_data(out_data), .out_err(out_err)
   );

   typedef struct {
      logic        clr, r0v, r1v, ordy, dov;
      logic [63:0] dout;
      logic        r0rdy, r1rdy, div, ovld, id, err;
      logic [63:0] data;
      logic        mode;
      logic [127:0] key;
   } vec_t;

   localparam logic [63:0] A  = 64'hA5A5_0000_0000_5A5A;
   localparam logic [63:0] X1 = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] X2 = 64'hFEDC_BA98_7654_3210;
   localparam logic [63:0] X3 = 64'h5555_AAAA_5555_AAAA;
   localparam logic [63:0] X4 = 64'h0F0F_1234_F0F0_4321;
   localparam logic [63:0] X5 = 64'hDEAD_BEEF_CAFE_F00D;
   localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

   vec_t tbl [22];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge; outputs are checked 1 unit later.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic vset(input int i, input logic c, input logic a, input logic b, input logic o,
                       input logic d, input logic [63:0] dt,
                       input logic e0, input logic e1, input logic ev, input logic ov,
                       input logic id, input logic er, input logic [63:0] da,
                       input logic md, input logic [127:0] k);
      tbl[i] = '{c, a, b, o, d, dt, e0, e1, ev, ov, id, er, da, md, k};
   endtask

   task automatic chk_resp(input string nm, input logic id, input logic er, input logic [63:0] da);
      chk({nm, ".out_vld"}, 128'(out_vld), 128'(1'b1));
      chk({nm, ".out_id"}, 128'(out_id), 128'(id));
      chk({nm, ".out_err"}, 128'(out_err), 128'(er));
      chk({nm, ".out_data"}, 128'(out_data), 128'(da));
   endtask

   initial begin
      clr = 1'b1; r0_vld = 0; r1_vld = 0; out_rdy = 1'b1; eng_do_vld = 0; eng_dout = '0;
      r0_din = 64'h0;              r0_key = 128'h1; r0_mode = 1'b0;
      r1_din = 64'h1111_2222_3333_4444; r1_key = 128'h2; r1_mode = 1'b1;

      //      i  clr r0v r1v ordy dov dout | r0rdy r1rdy div ovld id err data mode key
      vset( 0, 0, 1, 0, 1, 0, '0, 1, 0, 0, 0, 0, 0, '0, 0, 128'h0);
      vset( 1, 0, 0, 0, 1, 0, '0, 0, 0, 1, 0, 0, 0, '0, 0, 128'h1);
      vset( 2, 0, 0, 0, 1, 0, '0, 0, 0, 0, 0, 0, 0, '0, 0, 128'h1);
      vset( 3, 0, 0, 0, 1, 0, '0, 0, 0, 0, 0, 0, 0, '0, 0, 128'h1);
      vset( 4, 0, 0, 0, 1, 1, A,  0, 0, 0, 0, 0, 0, '0, 0, 128'h1);
      vset( 5, 0, 0, 0, 1, 0, '0, 0, 0, 0, 1, 0, 0, A,  0, 128'h1);
      vset( 6, 0, 0, 0, 1, 1, FF, 0, 0, 0, 0, 0, 0, A,  0, 128'h1);
      vset( 7, 0, 0, 0, 1, 0, '0, 0, 0, 0, 0, 0, 0, A,  0, 128'h1);
      vset( 8, 1, 1, 1, 1, 0, '0, 0, 0, 0, 0, 0, 0, A,  0, 128'h1);
      vset( 9, 0, 1, 1, 1, 0, '0, 1, 0, 0, 0, 0, 0, '0, 0, 128'h0);
      vset(10, 0, 1, 1, 1, 0, '0, 0, 0, 1, 0, 0, 0, '0, 0, 128'h1);
      vset(11, 0, 1, 1, 1, 1, X1, 0, 0, 0, 0, 0, 0, '0, 0, 128'h1);
      vset(12, 0, 1, 1, 1, 0, '0, 0, 0, 0, 1, 0, 0, X1, 0, 128'h1);
      vset(13, 0, 1, 1, 1, 0, '0, 0, 1, 0, 0, 0, 0, X1, 0, 128'h1);
      vset(14, 0, 1, 1, 1, 0, '0, 0, 0, 1, 0, 0, 0, X1, 1, 128'h2);
      vset(15, 0, 1, 1, 1, 1, X2, 0, 0, 0, 0, 0, 0, X1, 1, 128'h2);
      vset(16, 0, 1, 1, 1, 0, '0, 0, 0, 0, 1, 1, 0, X2, 1, 128'h2);
      vset(17, 0, 1, 1, 1, 0, '0, 1, 0, 0, 0, 1, 0, X2, 1, 128'h2);
      vset(18, 0, 1, 1, 1, 0, '0, 0, 0, 1, 0, 1, 0, X2, 0, 128'h1);
      vset(19, 0, 1, 1, 1, 1, X3, 0, 0, 0, 0, 1, 0, X2, 0, 128'h1);
      vset(20, 0, 1, 1, 1, 0, '0, 0, 0, 0, 1, 0, 0, X3, 0, 128'h1);
      vset(21, 0, 1, 1, 1, 0, '0, 0, 1, 0, 0, 0, 0, X3, 0, 128'h1);

      // Reset state
      tick(); tick(); tick();
      #1;
      chk("rst.r0_rdy", 128'(r0_rdy), 128'(0));
      chk("rst.r1_rdy", 128'(r1_rdy), 128'(0));
      chk("rst.eng_di_vld", 128'(eng_di_vld), 128'(0));
      chk("rst.out_vld", 128'(out_vld), 128'(0));
      chk("rst.out_id_err", 128'({out_id, out_err}), 128'(0));
      chk("rst.out_data", 128'(out_data), 128'(0));
      chk("rst.eng_din", 128'(eng_din), 128'(0));
      chk("rst.eng_key", eng_key, 128'(0));
      chk("rst.eng_mode", 128'(eng_mode), 128'(0));

      // Single job, stray engine pulse in IDLE, reset with both pending, round-robin contention
      foreach (tbl[i]) begin
         tick();
         clr = tbl[i].clr; r0_vld = tbl[i].r0v; r1_vld = tbl[i].r1v; out_rdy = tbl[i].ordy;
         eng_do_vld = tbl[i].dov; eng_dout = tbl[i].dout;
         #1;
         chk($sformatf("row%0d.r0_rdy", i), 128'(r0_rdy), 128'(tbl[i].r0rdy));
         chk($sformatf("row%0d.r1_rdy", i), 128'(r1_rdy), 128'(tbl[i].r1rdy));
         chk($sformatf("row%0d.eng_di_vld", i), 128'(eng_di_vld), 128'(tbl[i].div));
         chk($sformatf("row%0d.out_vld", i), 128'(out_vld), 128'(tbl[i].ovld));
         chk($sformatf("row%0d.out_id", i), 128'(out_id), 128'(tbl[i].id));
         chk($sformatf("row%0d.out_err", i), 128'(out_err), 128'(tbl[i].err));
         chk($sformatf("row%0d.out_data", i), 128'(out_data), 128'(tbl[i].data));
         chk($sformatf("row%0d.eng_mode", i), 128'(eng_mode), 128'(tbl[i].mode));
         chk($sformatf("row%0d.eng_key", i), eng_key, tbl[i].key);
      end

      // Timeout on the job granted to r1 in the last row
      tick(); r0_vld = 0; r1_vld = 0; eng_do_vld = 0; #1;
      chk("tmo.issue", 128'(eng_di_vld), 128'(1));
      chk("tmo.eng_din", 128'(eng_din), 128'(r1_din));
      for (int k = 1; k <= 64; k++) begin
         tick(); #1;
         chk($sformatf("tmo.wait%0d.out_vld", k), 128'(out_vld), 128'(0));
      end
      // Backpressure in RESP with both requesters pending and a stray engine pulse
      for (int k = 0; k < 10; k++) begin
         tick(); out_rdy = 0; r0_vld = 1; r1_vld = 1; eng_do_vld = 1; eng_dout = FF; #1;
         chk_resp($sformatf("bp%0d", k), 1'b1, 1'b1, 64'd0);
         chk($sformatf("bp%0d.rdy_div", k), 128'({r0_rdy, r1_rdy, eng_di_vld}), 128'(0));
      end
      tick(); out_rdy = 1; eng_do_vld = 0; #1;
      chk_resp("bp_exit", 1'b1, 1'b1, 64'd0);
      tick(); #1;
      chk("after_bp.out_vld", 128'(out_vld), 128'(0));
      chk("after_bp.grant", 128'({r0_rdy, r1_rdy}), 128'(2'b10));

      // Response arriving on the same cycle as the timeout wins
      tick(); r0_vld = 0; r1_vld = 0; #1;
      chk("race.issue", 128'(eng_di_vld), 128'(1));
      for (int k = 1; k <= 64; k++) begin
         tick();
         eng_do_vld = (k == 64); eng_dout = (k == 64) ? X4 : 64'd0;
         #1;
         chk($sformatf("race.wait%0d.out_vld", k), 128'(out_vld), 128'(0));
      end
      tick(); eng_do_vld = 0; #1;
      chk_resp("race", 1'b0, 1'b0, X4);

      // Reset in WAIT, then a late engine pulse
      tick(); r1_vld = 1; #1;
      chk("mid.grant", 128'({r0_rdy, r1_rdy}), 128'(2'b01));
      tick(); r1_vld = 0; #1;
      chk("mid.issue", 128'(eng_di_vld), 128'(1));
      tick(); #1;
      tick(); clr = 1; #1;
      tick(); clr = 0; eng_do_vld = 1; eng_dout = X5; #1;
      chk("mid.out_vld", 128'(out_vld), 128'(0));
      chk("mid.out_data", 128'(out_data), 128'(0));
      tick(); eng_do_vld = 0; r0_vld = 1; r1_vld = 1; #1;
      chk("mid.late.out_vld", 128'(out_vld), 128'(0));
      chk("mid.idle_rr0", 128'({r0_rdy, r1_rdy}), 128'(2'b10));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/crypt_sched.md
CRYPT_SCHED -- requirements
Module: crypt_sched

Interface
REQ-001 Parameter TIMEOUT, default 64, maximum engine wait cycles before abort (legal range 1..255).
REQ-002 clk  in  1  single system clock; all logic rising-edge.
REQ-003 clr  in  1  reset, synchronous, active-high.
REQ-004 r0_vld  in  1  requester 0 has a block pending.
REQ-005 r0_rdy  out  1  one-cycle accept strobe to requester 0.
REQ-006 r0_din  in  64  requester 0 data block.
REQ-007 r0_key  in  128  requester 0 key.
REQ-008 r0_mode  in  1  requester 0 operation (0 encrypt, 1 decrypt).
REQ-009 r1_vld, r1_rdy, r1_din, r1_key, r1_mode: same widths and meanings for requester 1.
REQ-010 eng_din  out  64  block to shared cipher engine.
REQ-011 eng_key  out  128  key to engine.
REQ-012 eng_mode  out  1  engine operation select.
REQ-013 eng_di_vld  out  1  one-cycle start pulse to engine.
REQ-014 eng_dout  in  64  engine result.
REQ-015 eng_do_vld  in  1  engine result valid, single-cycle.
REQ-016 out_vld  out  1  result available.
REQ-017 out_rdy  in  1  consumer accepts result.
REQ-018 out_id  out  1  index of requester owning result.
REQ-019 out_data  out  64  result block.
REQ-020 out_err  out  1  result aborted by timeout.

Function
REQ-021 FSM states IDLE, ISSUE, WAIT, RESP; exactly one job in flight.
REQ-022 IDLE: if either r*_vld=1, grant one requester, assert its r*_rdy for that cycle only, register its din/key/mode into eng_din/eng_key/eng_mode, go ISSUE.
REQ-023 Arbitration round-robin: pointer rr; both valid -> grant rr; one valid -> grant it regardless of rr.
REQ-024 rr updated at grant to the non-granted index (granted 0 -> rr=1, granted 1 -> rr=0).
REQ-025 ISSUE: eng_di_vld=1 for exactly one cycle, wait counter cleared to 0, go WAIT.
REQ-026 WAIT: counter increments each cycle; eng_do_vld=1 -> capture eng_dout into out_data, out_err=0, go RESP.
REQ-027 WAIT: counter reaching TIMEOUT with no eng_do_vld -> out_data=0, out_err=1, go RESP; eng_do_vld in same cycle as timeout wins (out_err=0).
REQ-028 RESP: out_vld=1, out_id/out_data/out_err held stable until out_rdy=1; on that cycle go IDLE, out_vld=0 next cycle.
REQ-029 Earliest new grant is the cycle after RESP exits (no IDLE bypass); minimum 4 cycles grant-to-grant with engine latency 1.
REQ-030 eng_do_vld outside WAIT ignored; no state or output change.
REQ-031 r*_vld changes outside IDLE ignored; captured operands not re-sampled.
REQ-032 eng_din/eng_key/eng_mode held constant from grant until next grant.
REQ-033 r0_rdy and r1_rdy never both 1; eng_di_vld never 1 outside ISSUE.

Reset
REQ-034 clr=1 on a clock edge -> state IDLE, rr=0, counter=0, all outputs 0 next cycle, regardless of state.
REQ-035 Reset mid-job discards job; no out_vld produced for it; late eng_do_vld after reset ignored.
REQ-036 clr=1 has priority over all other inputs in the same cycle.

Verification
REQ-037 Single job: r0_vld=1, din=64'h0, key=128'h1, mode=0; engine returns 64'hA5A5_0000_0000_5A5A after 3 cycles -> r0_rdy pulse, eng_di_vld pulse next cycle, out_vld=1 out_id=0 out_err=0 out_data=64'hA5A5_0000_0000_5A5A.
REQ-038 Contention: r0_vld=r1_vld=1 continuously after reset, out_rdy=1 -> grants alternate 0,1,0,1; out_id alternates, first 0.
REQ-039 Timeout: TIMEOUT=64, engine never responds -> out_vld=1, out_err=1, out_data=0 exactly 64 WAIT cycles after ISSUE.
REQ-040 Backpressure: out_rdy=0 for 10 cycles in RESP -> outputs stable, no r*_rdy, no eng_di_vld; out_rdy=1 -> IDLE.
REQ-041 Reset mid-WAIT: clr=1 one cycle, then eng_do_vld=1 -> out_vld stays 0, state IDLE, rr=0.
REQ-042 Stray eng_do_vld in IDLE and in RESP -> no output change.
